// File: rtl/scmem_pkg.sv
// Shared scmem definitions: request payload types and address helpers used by
// the directory request queues.
package scmem_pkg;

    localparam int DR_DRIDBITS    = 6;
    localparam int DR_LINEOFFBITS = 6;
    localparam int SC_PADDRBITS   = 50;

    typedef logic [SC_PADDRBITS-1:0]                sc_paddr_t;
    typedef logic [DR_DRIDBITS-1:0]                 dr_drid_t;
    typedef logic [SC_PADDRBITS-DR_LINEOFFBITS-1:0] dr_line_t;

    typedef enum logic [1:0] {
        DR_CMD_READ_S  = 2'd0,
        DR_CMD_READ_M  = 2'd1,
        DR_CMD_READ_NC = 2'd2,
        DR_CMD_WRITE   = 2'd3
    } dr_cmd_t;

    typedef struct packed {
        dr_cmd_t   cmd;
        sc_paddr_t paddr;
    } I_l2todr_req_type;

    typedef struct packed {
        sc_paddr_t paddr;
    } I_l2todr_pfreq_type;

    typedef struct packed {
        dr_drid_t  drid;
        dr_cmd_t   cmd;
        sc_paddr_t paddr;
    } I_drtomem_req_type;

    typedef struct packed {
        sc_paddr_t paddr;
    } I_drtomem_pfreq_type;

    function automatic dr_line_t line_addr(input sc_paddr_t paddr);
        return paddr[SC_PADDRBITS-1:DR_LINEOFFBITS];
    endfunction

    function automatic sc_paddr_t req_paddr(input I_l2todr_req_type req);
        return req.paddr;
    endfunction

endpackage

// File: rtl/dr_ring.sv
// Shifting queue with index 0 as the oldest entry; optionally replaces the oldest
// (or, with protect_head, the next-oldest) entry when pushed while full.
module dr_ring #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter bit DROP_OLDEST = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    input  logic                           protect_head,
    output logic [WIDTH-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           dropped,
    output logic [DEPTH-1:0][WIDTH-1:0]    entries,
    output logic [DEPTH-1:0]               occ
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        do_pop;
    logic                        do_push;
    logic [AW-1:0]               tail;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dropped = DROP_OLDEST && push && full && !do_pop;
    assign do_push = push && (!full || do_pop || dropped);
    assign tail    = AW'(count - CW'(do_pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CW'(do_push && !dropped) - CW'(do_pop);
        end
    end

    // NOTE: entry storage has no reset; count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (dropped) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (i >= int'(protect_head)) mem[i] <= mem[i+1];
            end
            mem[DEPTH-1] <= din;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
            end
            // Later non-blocking write to the tail slot overrides the shift above.
            if (do_push) mem[tail] <= din;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) occ[i] = (CW'(i) < count);
    end

    assign head    = mem[0];
    assign entries = mem;

endmodule

// File: rtl/dr_reqq.sv
// Directory request queues: demand FIFO with back-pressure and a lossy prefetch
// ring that defers to demands and filters prefetches hitting queued demand lines.
module dr_reqq
    import scmem_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int PF_DEPTH  = 4,
    parameter bit PF_DEFER  = 1'b1,
    parameter bit PF_FILTER = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l2todr_req_valid,
    output logic                l2todr_req_retry,
    input  I_l2todr_req_type    l2todr_req,
    input  logic                l2todr_pfreq_valid,
    output logic                l2todr_pfreq_retry,
    input  I_l2todr_pfreq_type  l2todr_pfreq,
    output logic                drtomem_req_valid,
    input  logic                drtomem_req_retry,
    output I_drtomem_req_type   drtomem_req,
    output logic                drtomem_pfreq_valid,
    input  logic                drtomem_pfreq_retry,
    output I_drtomem_pfreq_type drtomem_pfreq,
    output logic [15:0]         pf_drop_cnt
);

    localparam int DMD_W = $bits(I_l2todr_req_type);
    localparam int PF_W  = $bits(I_l2todr_pfreq_type);
    localparam int DCW   = $clog2(REQ_DEPTH+1);
    localparam int PCW   = $clog2(PF_DEPTH+1);

    I_l2todr_req_type                dmd_head;
    logic [DCW-1:0]                  dmd_count;
    logic                            dmd_full;
    logic                            dmd_dropped;
    logic [REQ_DEPTH-1:0][DMD_W-1:0] dmd_entries;
    logic [REQ_DEPTH-1:0]            dmd_occ;
    logic                            dmd_push;
    logic                            dmd_pop;

    logic [PCW-1:0]                  pf_count;
    logic                            pf_full;
    logic                            pf_dropped;
    logic [PF_DEPTH-1:0][PF_W-1:0]   pf_entries;
    logic [PF_DEPTH-1:0]             pf_occ;
    logic                            pf_hit;
    logic                            pf_push;
    logic                            pf_pop;
    logic                            pf_hold;
    logic                            drop_inc;
    dr_drid_t                        drid;

    assign dmd_push = l2todr_req_valid && !l2todr_req_retry;
    assign dmd_pop  = drtomem_req_valid && !drtomem_req_retry;

    dr_ring #(.WIDTH(DMD_W), .DEPTH(REQ_DEPTH), .DROP_OLDEST(1'b0)) u_dmd_ring (
        .clk          (clk),
        .reset        (reset),
        .push         (dmd_push),
        .din          (l2todr_req),
        .pop          (dmd_pop),
        .protect_head (1'b0),
        .head         (dmd_head),
        .count        (dmd_count),
        .full         (dmd_full),
        .dropped      (dmd_dropped),
        .entries      (dmd_entries),
        .occ          (dmd_occ)
    );

    assign l2todr_req_retry  = dmd_full;
    assign drtomem_req_valid = (dmd_count != '0);

    always_comb begin
        drtomem_req       = '0;
        drtomem_req.drid  = drid;
        drtomem_req.cmd   = dmd_head.cmd;
        drtomem_req.paddr = dmd_head.paddr;
    end

    always_comb begin
        pf_hit = 1'b0;
        if (PF_FILTER) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                if (dmd_occ[i] &&
                    line_addr(req_paddr(dmd_entries[i])) == line_addr(l2todr_pfreq.paddr))
                    pf_hit = 1'b1;
            end
        end
    end

    assign l2todr_pfreq_retry = 1'b0;
    assign pf_push = l2todr_pfreq_valid && !pf_hit;
    assign pf_pop  = drtomem_pfreq_valid && !drtomem_pfreq_retry;

    // A presented-but-retried prefetch stays valid even if a demand arrives meanwhile.
    assign drtomem_pfreq_valid = (pf_count != '0) &&
                                 (!PF_DEFER || (dmd_count == '0) || pf_hold);

    dr_ring #(.WIDTH(PF_W), .DEPTH(PF_DEPTH), .DROP_OLDEST(1'b1)) u_pf_ring (
        .clk          (clk),
        .reset        (reset),
        .push         (pf_push),
        .din          (l2todr_pfreq),
        .pop          (pf_pop),
        .protect_head (drtomem_pfreq_valid),
        .head         (drtomem_pfreq),
        .count        (pf_count),
        .full         (pf_full),
        .dropped      (pf_dropped),
        .entries      (pf_entries),
        .occ          (pf_occ)
    );

    assign drop_inc = (l2todr_pfreq_valid && pf_hit) || pf_dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drid        <= '0;
            pf_hold     <= 1'b0;
            pf_drop_cnt <= '0;
        end else begin
            if (dmd_pop) drid <= drid + dr_drid_t'(1);
            pf_hold <= drtomem_pfreq_valid && drtomem_pfreq_retry;
            if (drop_inc && pf_drop_cnt != 16'hFFFF) pf_drop_cnt <= pf_drop_cnt + 16'd1;
        end
    end

    logic unused_sink;
    assign unused_sink = ^{dmd_dropped, dmd_entries, pf_full, pf_entries, pf_occ};

endmodule

// File: tb/tb_dr_reqq.sv
// Self-checking bench for dr_reqq: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_dr_reqq;
    import scmem_pkg::*;

    localparam int REQ_DEPTH = 4;
    localparam int PF_DEPTH  = 4;

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid;
    logic                req_retry;
    I_l2todr_req_type    req;
    logic                pf_valid;
    logic                pf_retry;
    I_l2todr_pfreq_type  pf;
    logic                mem_req_valid;
    logic                mem_req_retry;
    I_drtomem_req_type   mem_req;
    logic                mem_pf_valid;
    logic                mem_pf_retry;
    I_drtomem_pfreq_type mem_pf;
    logic [15:0]         drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    I_l2todr_req_type m_dq[$];
    sc_paddr_t        m_pq[$];
    int               m_drid;
    int               m_drop;
    bit               m_held;

    always #5 clk = ~clk;

    dr_reqq #(.REQ_DEPTH(REQ_DEPTH), .PF_DEPTH(PF_DEPTH), .PF_DEFER(1'b1), .PF_FILTER(1'b1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .l2todr_req_valid    (req_valid),
        .l2todr_req_retry    (req_retry),
        .l2todr_req          (req),
        .l2todr_pfreq_valid  (pf_valid),
        .l2todr_pfreq_retry  (pf_retry),
        .l2todr_pfreq        (pf),
        .drtomem_req_valid   (mem_req_valid),
        .drtomem_req_retry   (mem_req_retry),
        .drtomem_req         (mem_req),
        .drtomem_pfreq_valid (mem_pf_valid),
        .drtomem_pfreq_retry (mem_pf_retry),
        .drtomem_pfreq       (mem_pf),
        .pf_drop_cnt         (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = 1'b0;
        req           = '0;
        pf_valid      = 1'b0;
        pf            = '0;
        mem_req_retry = 1'b0;
        mem_pf_retry  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_dq.delete();
        m_pq.delete();
        m_drid = 0;
        m_drop = 0;
        m_held = 1'b0;
    endtask

    function automatic sc_paddr_t rand_paddr();
        return sc_paddr_t'(64'h10000 + 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63)));
    endfunction

    // Applies one clock edge worth of transfers to the model.
    task automatic model_step(input logic rv, input I_l2todr_req_type r, input logic pv,
                              input sc_paddr_t p, input logic mr, input logic mpr,
                              output logic accepted);
        bit dv, dpop, pfv, ppop, hit;
        dv   = m_dq.size() != 0;
        dpop = dv && !mr;
        pfv  = m_pq.size() != 0 && (m_dq.size() == 0 || m_held);
        ppop = pfv && !mpr;
        hit  = 1'b0;
        foreach (m_dq[i]) if ((m_dq[i].paddr >> 6) == (p >> 6)) hit = 1'b1;
        accepted = rv && m_dq.size() < REQ_DEPTH;
        if (dpop) begin
            void'(m_dq.pop_front());
            m_drid = (m_drid + 1) % 64;
        end
        if (accepted) m_dq.push_back(r);
        if (ppop) void'(m_pq.pop_front());
        if (pv) begin
            if (hit) begin
                m_drop++;
            end else begin
                if (m_pq.size() == PF_DEPTH) begin
                    m_pq.delete(pfv ? 1 : 0);
                    m_drop++;
                end
                m_pq.push_back(p);
            end
        end
        if (m_drop > 65535) m_drop = 65535;
        m_held = pfv && mpr;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (mem_pf_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pf_valid: got %b expected 0", mem_pf_valid); end
        n_checks++; if (req_retry !== 1'b0) begin n_errors++; $display("FAIL reset_req_retry: got %b expected 0", req_retry); end
        n_checks++; if (pf_retry !== 1'b0) begin n_errors++; $display("FAIL reset_pf_retry: got %b expected 0", pf_retry); end
        n_checks++; if (mem_req.drid !== 6'd0) begin n_errors++; $display("FAIL reset_drid: got %0d expected 0", mem_req.drid); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        sc_paddr_t pa[5];
        sc_paddr_t iss_pa[$];
        int        iss_drid[$];
        bit        acc;
        do_reset();
        mem_req_retry = 1'b1;
        for (int k = 0; k < 5; k++) pa[k] = sc_paddr_t'(64'h4000 + 64'(k) * 64'h100);
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req.cmd = DR_CMD_READ_S; req.paddr = pa[k];
            n_checks++; if (req_retry !== 1'b0) begin n_errors++; $display("FAIL b2b_accept%0d: retry %b expected 0", k, req_retry); end
            tick();
        end
        req.paddr = pa[4];
        n_checks++; if (req_retry !== 1'b1) begin n_errors++; $display("FAIL b2b_fifth_retry: got %b expected 1", req_retry); end
        tick();
        mem_req_retry = 1'b0;
        for (int c = 0; c < 30 && iss_pa.size() < 5; c++) begin
            if (mem_req_valid) begin iss_pa.push_back(mem_req.paddr); iss_drid.push_back(int'(mem_req.drid)); end
            acc = req_valid && !req_retry;
            tick();
            if (acc) req_valid = 1'b0;
        end
        n_checks++;
        if (iss_pa.size() != 5) begin
            n_errors++; $display("FAIL b2b_issue_count: got %0d expected 5", iss_pa.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++; if (iss_pa[k] !== pa[k]) begin n_errors++; $display("FAIL b2b_paddr%0d: got %0h expected %0h", k, iss_pa[k], pa[k]); end
                n_checks++; if (iss_drid[k] != k) begin n_errors++; $display("FAIL b2b_drid%0d: got %0d expected %0d", k, iss_drid[k], k); end
            end
        end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drained: valid %b expected 0", mem_req_valid); end
    endtask

    task automatic test_prefetch_drop();
        sc_paddr_t p[6];
        sc_paddr_t iss[$];
        sc_paddr_t exp_order[4];
        do_reset();
        mem_pf_retry = 1'b1;
        for (int k = 0; k < 6; k++) p[k] = sc_paddr_t'(64'h8000 + 64'(k) * 64'h40);
        exp_order[0] = p[0]; exp_order[1] = p[3]; exp_order[2] = p[4]; exp_order[3] = p[5];
        for (int k = 0; k < 6; k++) begin
            pf_valid = 1'b1; pf.paddr = p[k];
            tick();
            n_checks++;
            if (mem_pf_valid !== 1'b1 || mem_pf.paddr !== p[0]) begin
                n_errors++; $display("FAIL pf_hold_head%0d: valid %b paddr %0h expected 1 %0h", k, mem_pf_valid, mem_pf.paddr, p[0]);
            end
        end
        pf_valid = 1'b0;
        n_checks++; if (drop_cnt !== 16'd2) begin n_errors++; $display("FAIL pf_drop_cnt: got %0d expected 2", drop_cnt); end
        mem_pf_retry = 1'b0;
        for (int c = 0; c < 20 && iss.size() < 4; c++) begin
            if (mem_pf_valid) iss.push_back(mem_pf.paddr);
            tick();
        end
        n_checks++;
        if (iss.size() != 4) begin
            n_errors++; $display("FAIL pf_issue_count: got %0d expected 4", iss.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (iss[k] !== exp_order[k]) begin n_errors++; $display("FAIL pf_order%0d: got %0h expected %0h", k, iss[k], exp_order[k]); end
            end
        end
        n_checks++; if (mem_pf_valid !== 1'b0) begin n_errors++; $display("FAIL pf_drained: valid %b expected 0", mem_pf_valid); end
    endtask

    task automatic test_filter();
        sc_paddr_t iss[$];
        do_reset();
        mem_req_retry = 1'b1;
        req_valid = 1'b1; req.cmd = DR_CMD_READ_M; req.paddr = sc_paddr_t'(64'h1000);
        tick();
        req_valid = 1'b0;
        pf_valid = 1'b1; pf.paddr = sc_paddr_t'(64'h1020);
        tick();
        n_checks++; if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL filter_drop: got %0d expected 1", drop_cnt); end
        pf.paddr = sc_paddr_t'(64'h1040);
        tick();
        pf_valid = 1'b0;
        n_checks++; if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL filter_pass_drop: got %0d expected 1", drop_cnt); end
        mem_req_retry = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_pf_valid) iss.push_back(mem_pf.paddr);
            tick();
        end
        n_checks++;
        if (iss.size() != 1) begin
            n_errors++; $display("FAIL filter_issue_count: got %0d expected 1", iss.size());
        end else begin
            n_checks++; if (iss[0] !== sc_paddr_t'(64'h1040)) begin n_errors++; $display("FAIL filter_issue_paddr: got %0h expected 1040", iss[0]); end
        end
    endtask

    task automatic test_defer();
        do_reset();
        mem_pf_retry = 1'b1;
        req_valid = 1'b1; req.cmd = DR_CMD_READ_S; req.paddr = sc_paddr_t'(64'h3000);
        pf_valid  = 1'b1; pf.paddr = sc_paddr_t'(64'h5000);
        tick();
        req_valid = 1'b0; pf_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL defer_dmd_first: got %b expected 1", mem_req_valid); end
        n_checks++; if (mem_pf_valid !== 1'b0) begin n_errors++; $display("FAIL defer_pf_held_off: got %b expected 0", mem_pf_valid); end
        tick();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL defer_dmd_gone: got %b expected 0", mem_req_valid); end
        n_checks++;
        if (mem_pf_valid !== 1'b1 || mem_pf.paddr !== sc_paddr_t'(64'h5000)) begin
            n_errors++; $display("FAIL defer_pf_after_empty: valid %b paddr %0h expected 1 5000", mem_pf_valid, mem_pf.paddr);
        end
        req_valid = 1'b1; req.paddr = sc_paddr_t'(64'h3100);
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (mem_pf_valid !== 1'b1 || mem_pf.paddr !== sc_paddr_t'(64'h5000) || mem_req_valid !== 1'b1) begin
            n_errors++; $display("FAIL defer_pf_sticky: pf %b paddr %0h req %b expected 1 5000 1", mem_pf_valid, mem_pf.paddr, mem_req_valid);
        end
        mem_pf_retry = 1'b0;
        tick();
        n_checks++; if (mem_pf_valid !== 1'b0) begin n_errors++; $display("FAIL defer_pf_sent: got %b expected 0", mem_pf_valid); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL defer_no_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_drid_wrap();
        int pushed = 0;
        int done   = 0;
        do_reset();
        req_valid = 1'b1; req.cmd = DR_CMD_READ_NC; req.paddr = '0;
        for (int c = 0; c < 300 && done < 65; c++) begin
            if (mem_req_valid) begin
                if (done == 63) begin
                    n_checks++; if (mem_req.drid !== 6'd63) begin n_errors++; $display("FAIL drid_64th: got %0d expected 63", mem_req.drid); end
                end
                if (done == 64) begin
                    n_checks++; if (mem_req.drid !== 6'd0) begin n_errors++; $display("FAIL drid_wrap: got %0d expected 0", mem_req.drid); end
                end
                done++;
            end
            if (req_valid && !req_retry) pushed++;
            tick();
            req.paddr = sc_paddr_t'(64'(c + 1) * 64);
            req_valid = (pushed < 65);
        end
        n_checks++; if (done != 65) begin n_errors++; $display("FAIL drid_timeout: got %0d transfers expected 65", done); end
    endtask

    task automatic test_reset_mid();
        sc_paddr_t iss[$];
        do_reset();
        mem_req_retry = 1'b1; mem_pf_retry = 1'b1;
        pf_valid = 1'b1; pf.paddr = sc_paddr_t'(64'h9000);
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req.cmd = DR_CMD_WRITE; req.paddr = sc_paddr_t'(64'h6000 + 64'(k) * 64'h100);
            tick();
            pf_valid = 1'b0;
        end
        req_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre: got %b expected 1", mem_req_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_req_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (mem_pf_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_pf_valid: got %b expected 0", mem_pf_valid); end
        n_checks++; if (req_retry !== 1'b0) begin n_errors++; $display("FAIL rst_mid_retry: got %b expected 0", req_retry); end
        tick();
        reset = 1'b0;
        mem_req_retry = 1'b0; mem_pf_retry = 1'b0;
        req_valid = 1'b1; req.paddr = sc_paddr_t'(64'h7700);
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_req_valid) iss.push_back(mem_req.paddr);
            n_checks++; if (mem_pf_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_pf_leak%0d: got %b expected 0", c, mem_pf_valid); end
            tick();
        end
        n_checks++;
        if (iss.size() != 1 || iss[0] !== sc_paddr_t'(64'h7700)) begin
            n_errors++; $display("FAIL rst_mid_first_accept: got %0d issues (first %0h) expected 1 issue 7700",
                                 iss.size(), (iss.size() != 0) ? iss[0] : '0);
        end
    endtask

    task automatic test_random();
        logic      pend = 1'b0;
        logic      acc;
        bit        exp_pfv;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            exp_pfv = m_pq.size() != 0 && (m_dq.size() == 0 || m_held);
            n_checks++; if (mem_req_valid !== (m_dq.size() != 0)) begin n_errors++; $display("FAIL rnd_req_valid@%0d: got %b expected %b", c, mem_req_valid, m_dq.size() != 0); end
            if (m_dq.size() != 0) begin
                n_checks++;
                if (mem_req.paddr !== m_dq[0].paddr || mem_req.cmd !== m_dq[0].cmd) begin
                    n_errors++; $display("FAIL rnd_req_head@%0d: got %0h/%0d expected %0h/%0d", c, mem_req.paddr, mem_req.cmd, m_dq[0].paddr, m_dq[0].cmd);
                end
            end
            n_checks++; if (int'(mem_req.drid) != m_drid) begin n_errors++; $display("FAIL rnd_drid@%0d: got %0d expected %0d", c, mem_req.drid, m_drid); end
            n_checks++; if (req_retry !== (m_dq.size() == REQ_DEPTH)) begin n_errors++; $display("FAIL rnd_retry@%0d: got %b expected %b", c, req_retry, m_dq.size() == REQ_DEPTH); end
            n_checks++; if (mem_pf_valid !== exp_pfv) begin n_errors++; $display("FAIL rnd_pf_valid@%0d: got %b expected %b", c, mem_pf_valid, exp_pfv); end
            if (exp_pfv) begin
                n_checks++; if (mem_pf.paddr !== m_pq[0]) begin n_errors++; $display("FAIL rnd_pf_head@%0d: got %0h expected %0h", c, mem_pf.paddr, m_pq[0]); end
            end
            n_checks++; if (int'(drop_cnt) != m_drop) begin n_errors++; $display("FAIL rnd_drop_cnt@%0d: got %0d expected %0d", c, drop_cnt, m_drop); end
            if (!pend) begin
                req_valid = ($urandom_range(0, 99) < 50);
                req.cmd   = dr_cmd_t'($urandom_range(0, 3));
                req.paddr = rand_paddr();
            end
            pf_valid      = ($urandom_range(0, 99) < 40);
            pf.paddr      = rand_paddr();
            mem_req_retry = ($urandom_range(0, 99) < 40);
            mem_pf_retry  = ($urandom_range(0, 99) < 50);
            model_step(req_valid, req, pf_valid, pf.paddr, mem_req_retry, mem_pf_retry, acc);
            pend = req_valid && !acc;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_pf_retry = 1'b1;
        pf_valid = 1'b1;
        for (int i = 0; i < 65538; i++) begin
            pf.paddr = sc_paddr_t'(64'(i) << 6);
            tick();
        end
        n_checks++; if (drop_cnt !== 16'hFFFE) begin n_errors++; $display("FAIL sat_below: got %0h expected fffe", drop_cnt); end
        for (int i = 0; i < 7; i++) begin
            pf.paddr = sc_paddr_t'(64'(i + 65538) << 6);
            tick();
        end
        pf_valid = 1'b0;
        n_checks++; if (drop_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold: got %0h expected ffff", drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_prefetch_drop();
        test_filter();
        test_defer();
        test_drid_wrap();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dr_reqq.md
DR_REQQ -- requirements
Module: dr_reqq

Interface
REQ-001 Parameter REQ_DEPTH, default 4: demand queue entries, power of two, >=2.
REQ-002 Parameter PF_DEPTH, default 4: prefetch queue entries, power of two, >=2.
REQ-003 Parameter PF_DEFER, default 1: 1 holds prefetch issue while the demand queue is non-empty.
REQ-004 Parameter PF_FILTER, default 1: 1 drops prefetches whose line address matches a queued demand.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 l2todr_req_valid / l2todr_req_retry / l2todr_req  in / out / I_l2todr_req_type  demand request from L2.
REQ-008 l2todr_pfreq_valid / l2todr_pfreq_retry / l2todr_pfreq  in / out / I_l2todr_pfreq_type  prefetch request from L2.
REQ-009 drtomem_req_valid / drtomem_req_retry / drtomem_req  out / in / I_drtomem_req_type  demand request to memory.
REQ-010 drtomem_pfreq_valid / drtomem_pfreq_retry / drtomem_pfreq  out / in / I_drtomem_pfreq_type  prefetch to memory.
REQ-011 pf_drop_cnt  out  16  saturating count of dropped prefetches.

Function
REQ-012 A transfer on any channel SHALL occur in a cycle with valid=1 and retry=0; payload SHALL be held stable while valid=1 and retry=1.
REQ-013 Demand path SHALL be a FIFO of REQ_DEPTH entries; minimum latency l2todr_req accept to drtomem_req_valid SHALL be 1 cycle; no combinational input-to-output path.
REQ-014 l2todr_req_retry SHALL equal (demand count == REQ_DEPTH), independent of drtomem_req_retry in the same cycle.
REQ-015 Simultaneous push and pop on the demand FIFO SHALL leave count unchanged, including at full and at count 1.
REQ-016 drtomem_req.paddr and .cmd SHALL come from the head entry; .drid SHALL be a 6-bit counter, reset 0, incremented per drtomem_req transfer, wrapping 63->0.
REQ-017 Prefetch path SHALL be a ring of PF_DEPTH entries; l2todr_pfreq_retry SHALL be constant 0.
REQ-018 Prefetch push while full and no same-cycle pop SHALL discard the head (oldest), append the new entry, keep count at PF_DEPTH, and increment pf_drop_cnt.
REQ-019 Prefetch push while full with same-cycle pop SHALL drop nothing.
REQ-020 With PF_FILTER=1, a prefetch whose paddr[..6] (64B line) equals that of any valid demand entry SHALL not be enqueued and SHALL increment pf_drop_cnt; the filter SHALL not count a drop-oldest too.
REQ-021 drtomem_pfreq.paddr SHALL come from the prefetch head; drtomem_pfreq_valid SHALL be (prefetch count != 0) and, with PF_DEFER=1, (demand count == 0).
REQ-022 Once drtomem_pfreq_valid=1 is asserted, it SHALL stay asserted until transfer even if a demand arrives, and the head SHALL not be dropped.
REQ-023 The prefetch head entry SHALL be excluded from drop-oldest while drtomem_pfreq_valid=1 and retry=1; the next-oldest entry is dropped instead.
REQ-024 pf_drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-025 On reset assertion, asynchronously: both queues empty, drtomem_req_valid=0, drtomem_pfreq_valid=0, l2todr_req_retry=0, drid counter=0, pf_drop_cnt=0.
REQ-026 Reset mid-operation SHALL discard all queued entries without issuing them; first accept permitted in the first cycle after deassertion.

Structure
REQ-027 DR_DRIDBITS (6), DR_LINEOFFBITS (6) and the I_* request types SHALL live in the shared scmem package.
REQ-028 One sub-module, dr_ring (parametrised width/depth with optional drop-oldest), SHALL implement both queues.

Verification
REQ-029 Defaults, 5 back-to-back demands, drtomem_req_retry=1: 4 accepted, 5th sees retry=1; release retry -> 4 issued with drid 0,1,2,3, then 5th with drid 4.
REQ-030 6 prefetches A..F, drtomem_pfreq_retry=1 and valid held on A: queue holds A,D,E,F; pf_drop_cnt=2; release -> issue order A,D,E,F.
REQ-031 Demand paddr 0x1000 queued, prefetch 0x1020 -> not enqueued, pf_drop_cnt=1; prefetch 0x1040 -> enqueued.
REQ-032 PF_DEFER=1, prefetch queued, demand arrives same cycle -> demand issued first, drtomem_pfreq_valid=1 in the cycle after demand FIFO empties.
REQ-033 64 demand transfers -> drid wraps to 0 on the 65th; reset asserted with 3 entries queued -> all valids 0 immediately, nothing issued after release.
